// File: rtl/commit_trace_checker_if.sv
`default_nettype none
//==============================================================================
// Module : commit_trace_checker_if
// Brief  : Golden commit-record stream (valid/ready) feeding the trace checker.
// Rev    : 1.0  initial release
//==============================================================================
interface commit_trace_checker_if;
    logic        exp_valid;
    logic        exp_ready;
    logic [2:0]  exp_kind;
    logic [15:0] exp_pc;
    logic [15:0] exp_value;
    logic [15:0] exp_addr;
    logic [3:0]  exp_reg;

    modport master (
        output exp_valid, exp_kind, exp_pc, exp_value, exp_addr, exp_reg,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_kind, exp_pc, exp_value, exp_addr, exp_reg,
        output exp_ready
    );
endinterface
`default_nettype wire

// File: rtl/commit_trace_checker.sv
`default_nettype none
//==============================================================================
// Module : commit_trace_checker
// Brief  : Buffers golden commit records and checks them against live commits.
// Rev    : 1.0  initial release
//==============================================================================
module commit_trace_checker #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  chk_en,
    input  logic [15:0]           pc,
    input  logic                  hlt,
    input  logic                  regwrite,
    input  logic [3:0]            dst_reg,
    input  logic [15:0]           dst_data,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [15:0]           mem_addr,
    input  logic [15:0]           mem_data,
    commit_trace_checker_if.slave expStream,
    output logic                  done,
    output logic                  pass,
    output logic                  err_mismatch,
    output logic                  err_underrun,
    output logic                  err_timeout,
    output logic [31:0]           fail_inum,
    output logic [31:0]           inst_count,
    output logic [31:0]           cycle_count
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]        c_MAX_CYC = 32'(MAX_CYCLES);

    localparam logic [2:0] c_KIND_NOP   = 3'd0;
    localparam logic [2:0] c_KIND_REG   = 3'd1;
    localparam logic [2:0] c_KIND_LOAD  = 3'd2;
    localparam logic [2:0] c_KIND_STORE = 3'd3;
    localparam logic [2:0] c_KIND_HALT  = 3'd4;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] pc;
        logic [15:0] value;
        logic [15:0] addr;
        logic [3:0]  rg;
    } rec_t;

    rec_t               r_fifoMem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;

    rec_t        w_head;
    rec_t        w_inRec;
    logic        w_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_run;
    logic        w_empty;
    logic [2:0]  w_cls;
    logic        w_fieldsOk;
    logic        w_match;
    logic        w_haltOk;
    logic        w_underrun;
    logic        w_mismatch;
    logic        w_timeout;
    logic        w_anyErr;
    logic        w_errSeen;
    logic [31:0] w_cycleNext;

    // ---------------------------------------------------------------- FIFO
    assign w_ready             = (r_state != c_ST_DONE) && (r_count < c_DEPTH);
    assign expStream.exp_ready = w_ready;
    assign w_push              = expStream.exp_valid & w_ready;
    assign w_run               = (r_state == c_ST_RUN);
    assign w_empty             = (r_count == '0);
    // An empty FIFO never pops, so a same-cycle push cannot rescue a commit.
    assign w_pop               = w_run & ~w_empty;
    assign w_head              = r_fifoMem[r_rdPtr];

    assign w_inRec = '{kind:  expStream.exp_kind,
                       pc:    expStream.exp_pc,
                       value: expStream.exp_value,
                       addr:  expStream.exp_addr,
                       rg:    expStream.exp_reg};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= w_inRec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------- commit classification
    always_comb begin
        w_cls = c_KIND_NOP;
        if (regwrite && memread) begin
            w_cls = c_KIND_LOAD;
        end else if (regwrite) begin
            w_cls = c_KIND_REG;
        end else if (hlt) begin
            w_cls = c_KIND_HALT;
        end else if (memwrite) begin
            w_cls = c_KIND_STORE;
        end
    end

    always_comb begin
        w_fieldsOk = 1'b0;
        case (w_cls)
            c_KIND_NOP,
            c_KIND_HALT:  w_fieldsOk = (pc == w_head.pc);
            c_KIND_REG:   w_fieldsOk = (pc == w_head.pc) && (dst_reg == w_head.rg) &&
                                       (dst_data == w_head.value);
            c_KIND_LOAD:  w_fieldsOk = (pc == w_head.pc) && (dst_reg == w_head.rg) &&
                                       (dst_data == w_head.value) && (mem_addr == w_head.addr);
            c_KIND_STORE: w_fieldsOk = (pc == w_head.pc) && (mem_addr == w_head.addr) &&
                                       (mem_data == w_head.value);
            default:      w_fieldsOk = 1'b0;
        endcase
    end

    // Record kinds 5-7 can never equal a classification, so they always fail.
    assign w_match     = (w_head.kind == w_cls) && w_fieldsOk;
    assign w_haltOk    = w_pop & w_match & (w_cls == c_KIND_HALT);
    assign w_underrun  = w_run & w_empty;
    assign w_mismatch  = w_pop & ~w_match;
    assign w_cycleNext = cycle_count + 32'd1;
    assign w_timeout   = w_run & (w_cycleNext == c_MAX_CYC) & ~w_haltOk;
    assign w_anyErr    = w_underrun | w_mismatch | w_timeout;
    assign w_errSeen   = err_mismatch | err_underrun | err_timeout;

    // ----------------------------------------------------------- control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_IDLE: if (chk_en) w_stateNext = c_ST_RUN;
            c_ST_RUN:  if (w_haltOk || w_anyErr) w_stateNext = c_ST_DONE;
            c_ST_DONE: w_stateNext = c_ST_DONE;
            default:   w_stateNext = c_ST_IDLE;
        endcase
    end

    assign done = (r_state == c_ST_DONE);

    // ------------------------------------------------------ status/counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass         <= 1'b0;
            err_mismatch <= 1'b0;
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
            fail_inum    <= '0;
            inst_count   <= '0;
            cycle_count  <= '0;
        end else if (w_run) begin
            inst_count  <= inst_count + 32'd1;
            cycle_count <= w_cycleNext;
            if (w_underrun) begin
                err_underrun <= 1'b1;
            end
            if (w_mismatch) begin
                err_mismatch <= 1'b1;
            end
            if (w_timeout) begin
                err_timeout <= 1'b1;
            end
            if (w_anyErr && !w_errSeen) begin
                fail_inum <= inst_count;
            end
            if (w_haltOk) begin
                pass <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_checker.sv
`default_nettype none
//==============================================================================
// Module : tb_commit_trace_checker
// Brief  : Self-checking bench: vector table, directed corners, random episodes.
// Rev    : 1.0  initial release
//==============================================================================
module tb_commit_trace_checker;
    localparam int DEPTH = 8;
    localparam int MAXA  = 100000;
    localparam int MAXB  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chkEn, hlt, regwrite, memread, memwrite;
    logic [15:0] pc, dstData, memAddr, memData;
    logic [3:0]  dstReg;
    logic        expValid;
    logic [2:0]  expKind;
    logic [15:0] expPc, expValue, expAddr;
    logic [3:0]  expReg;

    logic        doneA, passA, errMA, errUA, errTA, readyA;
    logic [31:0] failA, instA, cycA;
    logic        doneB, passB, errMB, errUB, errTB, readyB;
    logic [31:0] failB, instB, cycB;

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    commit_trace_checker_if ifA ();
    commit_trace_checker_if ifB ();

    assign ifA.exp_valid = expValid;  assign ifB.exp_valid = expValid;
    assign ifA.exp_kind  = expKind;   assign ifB.exp_kind  = expKind;
    assign ifA.exp_pc    = expPc;     assign ifB.exp_pc    = expPc;
    assign ifA.exp_value = expValue;  assign ifB.exp_value = expValue;
    assign ifA.exp_addr  = expAddr;   assign ifB.exp_addr  = expAddr;
    assign ifA.exp_reg   = expReg;    assign ifB.exp_reg   = expReg;
    assign readyA = ifA.exp_ready;
    assign readyB = ifB.exp_ready;

    commit_trace_checker #(.FIFO_DEPTH(DEPTH), .MAX_CYCLES(MAXA)) dutA (
        .clk(clk), .rst_n(rst_n), .chk_en(chkEn), .pc(pc), .hlt(hlt), .regwrite(regwrite),
        .dst_reg(dstReg), .dst_data(dstData), .memread(memread), .memwrite(memwrite),
        .mem_addr(memAddr), .mem_data(memData), .expStream(ifA),
        .done(doneA), .pass(passA), .err_mismatch(errMA), .err_underrun(errUA),
        .err_timeout(errTA), .fail_inum(failA), .inst_count(instA), .cycle_count(cycA)
    );

    commit_trace_checker #(.FIFO_DEPTH(DEPTH), .MAX_CYCLES(MAXB)) dutB (
        .clk(clk), .rst_n(rst_n), .chk_en(chkEn), .pc(pc), .hlt(hlt), .regwrite(regwrite),
        .dst_reg(dstReg), .dst_data(dstData), .memread(memread), .memwrite(memwrite),
        .mem_addr(memAddr), .mem_data(memData), .expStream(ifB),
        .done(doneB), .pass(passB), .err_mismatch(errMB), .err_underrun(errUB),
        .err_timeout(errTB), .fail_inum(failB), .inst_count(instB), .cycle_count(cycB)
    );

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] pc;
        logic [15:0] value;
        logic [15:0] addr;
        logic [3:0]  rg;
    } rec_t;

    typedef struct packed {
        logic [2:0]  eKind;
        logic [15:0] ePc, eVal, eAddr;
        logic [3:0]  eReg;
        logic [15:0] cPc;
        logic        cHlt, cRw, cMr, cMw;
        logic [3:0]  cReg;
        logic [15:0] cData, cAddr, cMdata;
        logic        xMis, xPass;
    } vec_t;

    // Reference model of dutA: a record queue plus plain flags and counters.
    rec_t        mq[$];
    int          mState;   // 0 idle, 1 checking, 2 finished
    bit          mPass, mErrM, mErrU, mErrT;
    logic [31:0] mFail, mInst, mCyc;
    rec_t        prog[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            if (nErr <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] commitKind();
        if (regwrite && memread) return 3'd2;
        if (regwrite)            return 3'd1;
        if (hlt)                 return 3'd4;
        if (memwrite)            return 3'd3;
        return 3'd0;
    endfunction

    function automatic bit recMatches(input rec_t r, input logic [2:0] k);
        bit pcOk, regOk;
        pcOk  = (pc == r.pc);
        regOk = (dstReg == r.rg) && (dstData == r.value);
        if (r.kind != k) return 1'b0;
        case (k)
            3'd0, 3'd4: return pcOk;
            3'd1:       return pcOk && regOk;
            3'd2:       return pcOk && regOk && (memAddr == r.addr);
            3'd3:       return pcOk && (memAddr == r.addr) && (memData == r.value);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit modelReady();
        return (mState != 2) && (mq.size() < DEPTH);
    endfunction

    task automatic modelReset();
        mq.delete();
        mState = 0; mPass = 0; mErrM = 0; mErrU = 0; mErrT = 0;
        mFail = 0; mInst = 0; mCyc = 0;
    endtask

    task automatic modelStep();
        bit doPush, u, m, t, hOk;
        logic [2:0] k;
        rec_t h, nr;
        doPush = expValid && modelReady();
        if (mState == 0) begin
            if (chkEn) mState = 1;
        end else if (mState == 1) begin
            k = commitKind();
            u = 0; m = 0; hOk = 0;
            if (mq.size() == 0) u = 1;
            else begin
                h = mq.pop_front();
                if (recMatches(h, k)) hOk = (k == 3'd4);
                else m = 1;
            end
            t = ((mCyc + 1) == MAXA) && !hOk;
            if ((u || m || t) && !(mErrU || mErrM || mErrT)) mFail = mInst;
            if (u) mErrU = 1;
            if (m) mErrM = 1;
            if (t) mErrT = 1;
            if (hOk) mPass = 1;
            if (u || m || t || hOk) mState = 2;
            mInst++;
            mCyc++;
        end
        if (doPush) begin
            nr = '{kind: expKind, pc: expPc, value: expValue, addr: expAddr, rg: expReg};
            mq.push_back(nr);
        end
    endtask

    task automatic compareAll();
        check("ready", readyA, modelReady());
        check("done", doneA, mState == 2);
        check("pass", passA, mPass);
        check("err_mismatch", errMA, mErrM);
        check("err_underrun", errUA, mErrU);
        check("err_timeout", errTA, mErrT);
        check("fail_inum", failA, mFail);
        check("inst_count", instA, mInst);
        check("cycle_count", cycA, mCyc);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic idleInputs();
        chkEn = 0; hlt = 0; regwrite = 0; memread = 0; memwrite = 0;
        pc = 0; dstData = 0; memAddr = 0; memData = 0; dstReg = 0;
        expValid = 0; expKind = 0; expPc = 0; expValue = 0; expAddr = 0; expReg = 0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        idleInputs();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic rec_t randRec(input int maxKind);
        rec_t r;
        r.kind  = 3'($urandom_range(maxKind));
        r.pc    = 16'($urandom);
        r.value = 16'($urandom);
        r.addr  = 16'($urandom);
        r.rg    = 4'($urandom);
        return r;
    endfunction

    task automatic presentRec(input rec_t r);
        expKind = r.kind; expPc = r.pc; expValue = r.value; expAddr = r.addr; expReg = r.rg;
    endtask

    // Drive a commit that matches r (unused fields random), optionally corrupted.
    task automatic driveCommit(input rec_t r, input bit bad);
        pc = r.pc; dstReg = 4'($urandom); dstData = 16'($urandom);
        memAddr = 16'($urandom); memData = 16'($urandom);
        hlt = 0; regwrite = 0; memwrite = 0; memread = 1'($urandom);
        case (r.kind)
            3'd1: begin regwrite = 1; memread = 0; hlt = 1'($urandom); memwrite = 1'($urandom);
                        dstReg = r.rg; dstData = r.value; end
            3'd2: begin regwrite = 1; memread = 1; hlt = 1'($urandom); memwrite = 1'($urandom);
                        dstReg = r.rg; dstData = r.value; memAddr = r.addr; end
            3'd3: begin memwrite = 1; memAddr = r.addr; memData = r.value; end
            3'd4: begin hlt = 1; memwrite = 1'($urandom); end
            default: ;
        endcase
        if (bad) begin
            case (r.kind)
                3'd1, 3'd2: dstData = dstData ^ 16'h0001;
                3'd3:       memData = memData ^ 16'h0001;
                default:    pc = pc ^ 16'h0001;
            endcase
        end
    endtask

    task automatic runProgram(input int nPre, input int pushPct, input int corruptPct,
                              input int badIdx, input int budget);
        int pushIdx = 0, comIdx = 0, cyc = 0;
        bit acc;
        doReset();
        while (pushIdx < nPre && cyc < budget) begin
            presentRec(prog[pushIdx]);
            expValid = 1;
            driveCommit(randRec(4), 0);
            acc = readyA;
            tick();
            if (acc) pushIdx++;
            cyc++;
        end
        if (nPre == DEPTH) check("full_ready", readyA, 0);
        expValid = 0; chkEn = 1;
        tick();
        chkEn = 0;
        while (mState == 1 && cyc < budget) begin
            expValid = 0;
            if (pushIdx < prog.size()) begin
                presentRec(prog[pushIdx]);
                expValid = ($urandom_range(99) < pushPct);
            end
            if (comIdx < prog.size())
                driveCommit(prog[comIdx], (comIdx == badIdx) || ($urandom_range(99) < corruptPct));
            else
                driveCommit(randRec(4), 0);
            acc = expValid && readyA;
            tick();
            if (acc) pushIdx++;
            comIdx++;
            cyc++;
        end
        check("run_finished_in_budget", doneA, 1);
        idleInputs();
    endtask

    vec_t tbl[13];

    initial begin
        rec_t r;
        int n;
        tbl[0]  = '{3'd0, 16'h0010, 16'h1111, 16'h2222, 4'd1, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b0, 1'b0};
        tbl[1]  = '{3'd1, 16'h0020, 16'h1234, 16'h0000, 4'd5, 16'h0020, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 16'h1234, 16'h7777, 16'h8888, 1'b0, 1'b0};
        tbl[2]  = '{3'd2, 16'h0030, 16'hBEEF, 16'h4000, 4'd2, 16'h0030, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 16'hBEEF, 16'h4000, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{3'd2, 16'h0030, 16'hBEEF, 16'h4000, 4'd2, 16'h0030, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 16'hBEEF, 16'h4001, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{3'd3, 16'h0040, 16'h5555, 16'h8000, 4'd0, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 16'h9999, 16'h8000, 16'h5555, 1'b0, 1'b0};
        tbl[5]  = '{3'd3, 16'h0040, 16'h5555, 16'h8000, 4'd0, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h9999, 16'h8000, 16'h5554, 1'b1, 1'b0};
        tbl[6]  = '{3'd4, 16'h0050, 16'h0000, 16'h0000, 4'd0, 16'h0050, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b1};
        tbl[7]  = '{3'd4, 16'h0050, 16'h0000, 16'h0000, 4'd0, 16'h0052, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[8]  = '{3'd5, 16'h0060, 16'h0000, 16'h0000, 4'd0, 16'h0060, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{3'd1, 16'h0070, 16'h00A5, 16'h0100, 4'd3, 16'h0070, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h00A5, 16'h0100, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{3'd0, 16'h0080, 16'h0000, 16'h0000, 4'd0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{3'd1, 16'h0090, 16'h00A5, 16'h0000, 4'd3, 16'h0090, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 16'h00A5, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[12] = '{3'd3, 16'h00A0, 16'h1234, 16'hC000, 4'd0, 16'h00A0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'hC002, 16'h1234, 1'b1, 1'b0};

        // Reset state.
        doReset();
        check("rst_done", doneA, 0);
        check("rst_pass", passA, 0);
        check("rst_err_mismatch", errMA, 0);
        check("rst_err_underrun", errUA, 0);
        check("rst_err_timeout", errTA, 0);
        check("rst_fail_inum", failA, 0);
        check("rst_inst_count", instA, 0);
        check("rst_cycle_count", cycA, 0);
        check("rst_ready", readyA, 1);
        check("rst_ready_b", readyB, 1);

        // Single-commit vectors covering classification priority and fields.
        foreach (tbl[i]) begin
            doReset();
            presentRec('{kind: tbl[i].eKind, pc: tbl[i].ePc, value: tbl[i].eVal,
                         addr: tbl[i].eAddr, rg: tbl[i].eReg});
            expValid = 1; chkEn = 1;
            tick();
            expValid = 0; chkEn = 0;
            pc = tbl[i].cPc; hlt = tbl[i].cHlt; regwrite = tbl[i].cRw; memread = tbl[i].cMr;
            memwrite = tbl[i].cMw; dstReg = tbl[i].cReg; dstData = tbl[i].cData;
            memAddr = tbl[i].cAddr; memData = tbl[i].cMdata;
            tick();
            check($sformatf("vec%0d_mismatch", i), errMA, tbl[i].xMis);
            check($sformatf("vec%0d_pass", i), passA, tbl[i].xPass);
            check($sformatf("vec%0d_done", i), doneA, tbl[i].xMis | tbl[i].xPass);
            check($sformatf("vec%0d_inst", i), instA, 1);
        end

        // NOP, REG r3=0x00A5, HALT all matching.
        prog.delete();
        prog.push_back('{kind: 3'd0, pc: 16'h0000, value: 16'h0, addr: 16'h0, rg: 4'd0});
        prog.push_back('{kind: 3'd1, pc: 16'h0002, value: 16'h00A5, addr: 16'h0, rg: 4'd3});
        prog.push_back('{kind: 3'd4, pc: 16'h0004, value: 16'h0, addr: 16'h0, rg: 4'd0});
        runProgram(3, 0, 0, -1, 20);
        check("prog_pass", passA, 1);
        check("prog_inst", instA, 3);
        check("prog_no_errors", {errMA, errUA, errTA}, 0);

        // Same program, REG data off by one at instruction 1.
        runProgram(3, 0, 0, 1, 20);
        check("mis_flag", errMA, 1);
        check("mis_fail_inum", failA, 1);
        check("mis_pass", passA, 0);
        check("mis_done", doneA, 1);

        // Empty FIFO at the first commit, push in the same cycle.
        doReset();
        chkEn = 1;
        tick();
        chkEn = 0;
        presentRec('{kind: 3'd0, pc: 16'h0000, value: 16'h0, addr: 16'h0, rg: 4'd0});
        expValid = 1;
        pc = 16'h0000;
        tick();
        expValid = 0;
        check("under_flag", errUA, 1);
        check("under_fail_inum", failA, 0);
        check("under_done", doneA, 1);

        // Timeout on dutB (MAX_CYCLES=4): four NOPs, then three NOPs + HALT.
        for (int v = 0; v < 2; v++) begin
            doReset();
            for (int j = 0; j < 4; j++) begin
                presentRec('{kind: (v == 1 && j == 3) ? 3'd4 : 3'd0, pc: 16'(j * 2),
                             value: 16'h0, addr: 16'h0, rg: 4'd0});
                expValid = 1;
                tick();
            end
            expValid = 0; chkEn = 1;
            tick();
            chkEn = 0;
            for (int j = 0; j < 4; j++) begin
                driveCommit('{kind: (v == 1 && j == 3) ? 3'd4 : 3'd0, pc: 16'(j * 2),
                              value: 16'h0, addr: 16'h0, rg: 4'd0}, 0);
                tick();
                if (j == 2) begin
                    check("to_early_flag", errTB, 0);
                    check("to_early_done", doneB, 0);
                end
            end
            check($sformatf("to%0d_err_timeout", v), errTB, v == 0);
            check($sformatf("to%0d_pass", v), passB, v == 1);
            check($sformatf("to%0d_done", v), doneB, 1);
            check($sformatf("to%0d_inst", v), instB, 4);
            check($sformatf("to%0d_fail_inum", v), failB, (v == 0) ? 3 : 0);
        end

        // FIFO fill to 8 in IDLE, then 20 records streamed through the wrap.
        prog.delete();
        for (int j = 0; j < 19; j++) prog.push_back(randRec(3));
        r = randRec(0); r.kind = 3'd4; prog.push_back(r);
        runProgram(DEPTH, 100, 0, -1, 100);
        check("wrap_pass", passA, 1);
        check("wrap_inst", instA, 20);

        // Asynchronous reset mid-run with three records queued.
        prog.delete();
        for (int j = 0; j < 6; j++) begin r = randRec(0); prog.push_back(r); end
        doReset();
        for (int j = 0; j < 4; j++) begin presentRec(prog[j]); expValid = 1; tick(); end
        expValid = 0; chkEn = 1;
        tick();
        chkEn = 0;
        driveCommit(prog[0], 0);
        tick();
        check("pre_rst_inst", instA, 1);
        rst_n = 1'b0;
        modelReset();
        #1;
        check("mid_rst_done", doneA, 0);
        check("mid_rst_inst", instA, 0);
        check("mid_rst_cycle", cycA, 0);
        check("mid_rst_ready", readyA, 1);
        check("mid_rst_errs", {errMA, errUA, errTA, passA}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleInputs();
        chkEn = 1;
        tick();
        chkEn = 0;
        driveCommit(prog[1], 0);
        tick();
        check("post_rst_flushed", errUA, 1);

        // Random episodes, each ending in HALT, with occasional corruption.
        for (int ep = 0; ep < 30; ep++) begin
            prog.delete();
            n = $urandom_range(4, 20);
            for (int j = 0; j < n - 1; j++) begin
                r = randRec(4);
                if ($urandom_range(99) < 3) r.kind = 3'($urandom_range(5, 7));
                prog.push_back(r);
            end
            r = randRec(0); r.kind = 3'd4; prog.push_back(r);
            runProgram($urandom_range(1, (n < DEPTH) ? n : DEPTH), $urandom_range(40, 100), 6, -1, 100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
